// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV64 5-stage core.
// ALU op encodings, the ID/EX control bundle and the x0 index.
package pipe_pkg;

    localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
    localparam logic [1:0] ALUOP_STORE  = 2'b01;
    localparam logic [1:0] ALUOP_BRANCH = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b11;

    localparam logic [4:0] X0 = 5'd0;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic [1:0] aluOp;
        logic [2:0] func3;
        logic [6:0] func7;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check between the load sitting in EX and the
// instruction in ID; also reused by the forwarding unit.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    output logic       o_haz
);

    logic ex_load;
    logic hit_rs1;
    logic hit_rs2;

    assign ex_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != X0);
    assign hit_rs1 = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign hit_rs2 = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_haz   = ex_load & i_id_valid & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush,
// downstream hold and saturating bubble/flush counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic             i_regWrite,
    input  logic             i_memRead,
    input  logic             i_memWrite,
    input  logic             i_memToReg,
    input  logic             i_aluSrc,
    input  logic             i_branch,
    input  logic [1:0]       i_aluOp,
    input  logic [2:0]       i_func3,
    input  logic [6:0]       i_func7,
    input  logic             i_uses_rs1,
    input  logic             i_uses_rs2,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [4:0]       i_rd,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_stall,
    output logic             o_valid,
    output logic             o_regWrite,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_memToReg,
    output logic             o_aluSrc,
    output logic             o_branch,
    output logic [1:0]       o_aluOp,
    output logic [2:0]       o_func3,
    output logic [6:0]       o_func7,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic [XLEN-1:0]  o_imm,
    output logic [XLEN-1:0]  o_pc,
    output logic [CNT_W-1:0] o_bubble_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  haz;
    logic  bubble;

    load_use_detect u_lud (
        .i_ex_valid    (o_valid),
        .i_ex_mem_read (ctrl_q.memRead),
        .i_ex_rd       (o_rd),
        .i_id_valid    (i_valid),
        .i_id_uses_rs1 (i_uses_rs1),
        .i_id_uses_rs2 (i_uses_rs2),
        .i_id_rs1      (i_rs1),
        .i_id_rs2      (i_rs2),
        .o_haz         (haz)
    );

    assign o_stall = i_hold | (haz & ~i_flush);
    assign bubble  = i_flush | haz | ~i_valid;

    assign ctrl_d = '{
        regWrite: i_regWrite,
        memRead:  i_memRead,
        memWrite: i_memWrite,
        memToReg: i_memToReg,
        aluSrc:   i_aluSrc,
        branch:   i_branch,
        aluOp:    i_aluOp,
        func3:    i_func3,
        func7:    i_func7
    };

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            ctrl_q       <= '0;
            o_rs1        <= '0;
            o_rs2        <= '0;
            o_rd         <= '0;
            o_rs1_data   <= '0;
            o_rs2_data   <= '0;
            o_imm        <= '0;
            o_pc         <= '0;
            o_bubble_cnt <= '0;
            o_flush_cnt  <= '0;
        end else if (!i_hold) begin
            // Bubbles are all-zero so EX sees deterministic contents
            if (bubble) begin
                o_valid    <= 1'b0;
                ctrl_q     <= '0;
                o_rs1      <= '0;
                o_rs2      <= '0;
                o_rd       <= '0;
                o_rs1_data <= '0;
                o_rs2_data <= '0;
                o_imm      <= '0;
                o_pc       <= '0;
            end else begin
                o_valid    <= 1'b1;
                ctrl_q     <= ctrl_d;
                o_rs1      <= i_rs1;
                o_rs2      <= i_rs2;
                o_rd       <= i_rd;
                o_rs1_data <= i_rs1_data;
                o_rs2_data <= i_rs2_data;
                o_imm      <= i_imm;
                o_pc       <= i_pc;
            end
            if (i_flush) begin
                if (o_flush_cnt != '1)
                    o_flush_cnt <= o_flush_cnt + CNT_W'(1);
            end else if (haz) begin
                if (o_bubble_cnt != '1)
                    o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign o_regWrite = ctrl_q.regWrite;
    assign o_memRead  = ctrl_q.memRead;
    assign o_memWrite = ctrl_q.memWrite;
    assign o_memToReg = ctrl_q.memToReg;
    assign o_aluSrc   = ctrl_q.aluSrc;
    assign o_branch   = ctrl_q.branch;
    assign o_aluOp    = ctrl_q.aluOp;
    assign o_func3    = ctrl_q.func3;
    assign o_func7    = ctrl_q.func7;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: load, load-use, x0/no-use,
// flush vs hazard, hold with async reset, counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_hold, i_flush;
    logic        i_regWrite, i_memRead, i_memWrite;
    logic        i_memToReg, i_aluSrc, i_branch;
    logic [1:0]  i_aluOp;
    logic [2:0]  i_func3;
    logic [6:0]  i_func7;
    logic        i_uses_rs1, i_uses_rs2;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [63:0] i_rs1_data, i_rs2_data, i_imm, i_pc;

    logic        o_stall, o_valid;
    logic        o_regWrite, o_memRead, o_memWrite;
    logic        o_memToReg, o_aluSrc, o_branch;
    logic [1:0]  o_aluOp;
    logic [2:0]  o_func3;
    logic [6:0]  o_func7;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [63:0] o_rs1_data, o_rs2_data, o_imm, o_pc;
    logic [15:0] o_bubble_cnt, o_flush_cnt;

    logic        s_stall, s_valid;
    logic        s_regWrite, s_memRead, s_memWrite;
    logic        s_memToReg, s_aluSrc, s_branch;
    logic [1:0]  s_aluOp;
    logic [2:0]  s_func3;
    logic [6:0]  s_func7;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [63:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
    logic [1:0]  s_bubble_cnt, s_flush_cnt;

    id_ex_stage #(.XLEN(64), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
        .i_hold(i_hold), .i_flush(i_flush),
        .i_regWrite(i_regWrite), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_memToReg(i_memToReg),
        .i_aluSrc(i_aluSrc), .i_branch(i_branch),
        .i_aluOp(i_aluOp), .i_func3(i_func3), .i_func7(i_func7),
        .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_pc(i_pc),
        .o_stall(o_stall), .o_valid(o_valid),
        .o_regWrite(o_regWrite), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_memToReg(o_memToReg),
        .o_aluSrc(o_aluSrc), .o_branch(o_branch),
        .o_aluOp(o_aluOp), .o_func3(o_func3), .o_func7(o_func7),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .o_imm(o_imm), .o_pc(o_pc),
        .o_bubble_cnt(o_bubble_cnt), .o_flush_cnt(o_flush_cnt)
    );

    id_ex_stage #(.XLEN(64), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
        .i_hold(i_hold), .i_flush(i_flush),
        .i_regWrite(i_regWrite), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_memToReg(i_memToReg),
        .i_aluSrc(i_aluSrc), .i_branch(i_branch),
        .i_aluOp(i_aluOp), .i_func3(i_func3), .i_func7(i_func7),
        .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_pc(i_pc),
        .o_stall(s_stall), .o_valid(s_valid),
        .o_regWrite(s_regWrite), .o_memRead(s_memRead),
        .o_memWrite(s_memWrite), .o_memToReg(s_memToReg),
        .o_aluSrc(s_aluSrc), .o_branch(s_branch),
        .o_aluOp(s_aluOp), .o_func3(s_func3), .o_func7(s_func7),
        .o_rs1(s_rs1), .o_rs2(s_rs2), .o_rd(s_rd),
        .o_rs1_data(s_rs1_data), .o_rs2_data(s_rs2_data),
        .o_imm(s_imm), .o_pc(s_pc),
        .o_bubble_cnt(s_bubble_cnt), .o_flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mr;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [15:0] bc;
        logic [15:0] fc;
    } obs_t;

    obs_t       sb[$];
    logic [1:0] sat_q[$];
    obs_t       e, g;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic obs_t mk(logic v, logic rw, logic mr,
                                logic [1:0] op, logic [4:0] rd,
                                logic [63:0] imm,
                                logic [15:0] bc, logic [15:0] fc);
        obs_t r;
        r = '{v: v, rw: rw, mr: mr, op: op, rd: rd,
              imm: imm, bc: bc, fc: fc};
        return r;
    endfunction

    function automatic obs_t cur();
        obs_t r;
        r = '{v: o_valid, rw: o_regWrite, mr: o_memRead,
              op: o_aluOp, rd: o_rd, imm: o_imm,
              bc: o_bubble_cnt, fc: o_flush_cnt};
        return r;
    endfunction

    task automatic drive(input logic v, input logic rw,
                         input logic mr, input logic [1:0] op,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic [63:0] imm);
        i_valid    = v;
        i_regWrite = rw;
        i_memRead  = mr;
        i_memWrite = 1'b0;
        i_memToReg = mr;
        i_aluSrc   = (op == 2'b00);
        i_branch   = 1'b0;
        i_aluOp    = op;
        i_func3    = mr ? 3'b011 : 3'b000;
        i_func7    = 7'd0;
        i_rs1      = rs1;
        i_uses_rs1 = u1;
        i_rs2      = rs2;
        i_uses_rs2 = u2;
        i_rd       = rd;
        i_imm      = imm;
        i_rs1_data = 64'hA0 + 64'(rs1);
        i_rs2_data = 64'hB0 + 64'(rs2);
        i_pc       = 64'h1000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 64'd0);
        #12;
        g = cur();
        n_tests++;
        if (g !== '0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got %h stall %b want 0", g, o_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd2, 1, 0, 0, 5'd5, 64'd16);
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_stall: got %b want 0", o_stall);
        end
        sb.push_back(mk(1, 1, 1, 2'b00, 5'd5, 64'd16, 0, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e || o_func3 !== 3'b011) begin
            n_fail++;
            $display("FAIL load_out: got %h f3 %b want %h f3 011",
                     g, o_func3, e);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(1, 1, 0, 2'b11, 5'd5, 1, 5'd7, 1, 5'd6, 64'd0);
        #1;
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 1", o_stall);
        end
        sb.push_back(mk(0, 0, 0, 2'b00, 0, 64'd0, 1, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL lu_bubble: got %h want %h", g, e);
        end
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_release: got %b want 0", o_stall);
        end
        sb.push_back(mk(1, 1, 0, 2'b11, 5'd6, 64'd0, 1, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL lu_add: got %h want %h", g, e);
        end
    endtask

    task automatic test_x0_nouse();
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd3, 1, 0, 0, 5'd0, 64'd8);
        sb.push_back(mk(1, 1, 1, 2'b00, 5'd0, 64'd8, 1, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL ld_x0: got %h want %h", g, e);
        end
        @(negedge clk);
        drive(1, 1, 0, 2'b00, 5'd0, 1, 5'd0, 1, 5'd7, 64'd3);
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_stall: got %b want 0", o_stall);
        end
        sb.push_back(mk(1, 1, 0, 2'b00, 5'd7, 64'd3, 1, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL x0_use: got %h want %h", g, e);
        end
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd1, 1, 0, 0, 5'd5, 64'd24);
        tick();
        @(negedge clk);
        drive(1, 1, 0, 2'b00, 5'd5, 0, 5'd5, 0, 5'd8, 64'h1000);
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nouse_stall: got %b want 0", o_stall);
        end
        sb.push_back(mk(1, 1, 0, 2'b00, 5'd8, 64'h1000, 1, 0));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL nouse_lui: got %h want %h", g, e);
        end
    endtask

    task automatic test_flush_haz();
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd1, 1, 0, 0, 5'd5, 64'd32);
        tick();
        @(negedge clk);
        drive(1, 1, 0, 2'b11, 5'd5, 1, 5'd7, 1, 5'd6, 64'd0);
        i_flush = 1'b1;
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fh_stall: got %b want 0", o_stall);
        end
        sb.push_back(mk(0, 0, 0, 2'b00, 0, 64'd0, 1, 1));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL fh_bubble: got %h want %h", g, e);
        end
        @(negedge clk);
        i_flush = 1'b0;
        sb.push_back(mk(1, 1, 0, 2'b11, 5'd6, 64'd0, 1, 1));
        tick();
        e = sb.pop_front();
        g = cur();
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL fh_add: got %h want %h", g, e);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd2, 1, 0, 0, 5'd9, 64'd40);
        i_hold  = 1'b1;
        i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (o_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stall%0d: got %b want 1", i, o_stall);
            end
            sb.push_back(mk(1, 1, 0, 2'b11, 5'd6, 64'd0, 1, 1));
            tick();
            e = sb.pop_front();
            g = cur();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL hold_frozen%0d: got %h want %h", i, g, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        g = cur();
        n_tests++;
        if (g !== '0 || s_flush_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL hold_async_rst: got %h sat %0d want 0",
                     g, s_flush_cnt);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 64'd0);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        drive(1, 1, 1, 2'b00, 5'd1, 1, 0, 0, 5'd5, 64'd8);
        i_flush = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(mk(0, 0, 0, 2'b00, 0, 64'd0, 0, 16'(i)));
            sat_q.push_back((i > 3) ? 2'd3 : 2'(i));
            tick();
            e = sb.pop_front();
            g = cur();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL flush_cnt%0d: got %h want %h", i, g, e);
            end
            n_tests++;
            if (s_flush_cnt !== sat_q[0]) begin
                n_fail++;
                $display("FAIL sat_cnt%0d: got %0d want %0d",
                         i, s_flush_cnt, sat_q[0]);
            end
            void'(sat_q.pop_front());
        end
        @(negedge clk);
        i_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_load();
        test_load_use();
        test_x0_nouse();
        test_flush_haz();
        test_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV64 pipeline. It captures decoded control, operands, immediate and register indices from ID, and presents them to EX.
- EX uses the outputs to drive alu_control (aluOp/func3/func7), the ALU operand mux and branch resolution.
- Contains load-use hazard detection (bubble insertion plus upstream stall), branch flush squashing, a downstream hold, and saturating bubble/flush event counters.

Parameters:
- XLEN, 64, operand/immediate/PC width
- CNT_W, 16, width of event counters

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  ID holds a real instruction
- i_hold  in  1  downstream (MEM) stall; freeze this stage
- i_flush  in  1  branch taken in EX; squash instruction entering from ID
- i_regWrite, i_memRead, i_memWrite, i_memToReg, i_aluSrc, i_branch  in  1 each  decoded control
- i_aluOp  in  2  00 I-type/load, 01 store, 10 branch, 11 R-type
- i_func3  in  3  instruction func3
- i_func7  in  7  instruction func7
- i_uses_rs1, i_uses_rs2  in  1 each  instruction reads rs1/rs2
- i_rs1, i_rs2, i_rd  in  5 each  register indices
- i_rs1_data, i_rs2_data, i_imm, i_pc  in  XLEN each  operands, immediate, PC
- o_stall  out  1  IF/ID and PC must hold this cycle (combinational)
- o_valid  out  1  registered valid
- o_regWrite, o_memRead, o_memWrite, o_memToReg, o_aluSrc, o_branch, o_aluOp, o_func3, o_func7, o_rs1, o_rs2, o_rd, o_rs1_data, o_rs2_data, o_imm, o_pc  out  as inputs  registered copies
- o_bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
- o_flush_cnt  out  CNT_W  flushes applied, saturating

Behaviour:
- Reset (async, i_rst_n=0): every registered output and both counters go to 0 immediately. A reset asserted mid-operation discards the in-flight instruction.
- Hazard (combinational): haz = o_valid & o_memRead & (o_rd!=0) & i_valid & ((i_uses_rs1 & i_rs1==o_rd) | (i_uses_rs2 & i_rs2==o_rd)).
- o_stall = i_hold | (haz & ~i_flush).
- Per-edge priority, highest first:
  1. i_hold=1: all registers keep their value; counters unchanged; i_flush is ignored, and EX must re-assert it after the hold releases.
  2. i_flush=1: load bubble; o_flush_cnt += 1.
  3. haz=1: load bubble; o_bubble_cnt += 1. ID contents are held upstream and enter on the next edge.
  4. Otherwise: load all inputs. o_valid = i_valid; if i_valid=0, load a bubble.
- Bubble: o_valid=0 and every control output (regWrite, memRead, memWrite, memToReg, aluSrc, branch) = 0. o_aluOp=00; func3, func7, indices and data = 0, so bubble contents are deterministic.
- Latency: 1 cycle from ID inputs to outputs.
- Load-use costs exactly one bubble. The cycle after a bubble, o_memRead=0, so haz clears.
- rd = x0 never triggers a hazard.
- An instruction with uses_rsN=0 never hazards on that field, even if the index matches.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Shared package (pipe_pkg) holds:
  - ALUOP_ITYPE=2'b00, ALUOP_STORE=2'b01, ALUOP_BRANCH=2'b10, ALUOP_RTYPE=2'b11
  - a packed struct for the control bundle (regWrite..func7)
  - X0 index constant
- One combinational sub-module, load_use_detect, computes haz. It is reused by a later forwarding unit.
- The register and counters remain in id_ex_stage.

Test Plan:
- Reset then a single load: i_valid=1, i_rd=5, i_memRead=1, i_aluOp=00, i_func3=011, i_imm=16 → one cycle later o_valid=1, o_rd=5, o_memRead=1, o_imm=16; o_stall=0.
- Load-use: ld x5 followed by add x6,x5,x7 (uses_rs1=1, rs1=5) → o_stall=1 for one cycle, next outputs are a bubble (o_valid=0, o_regWrite=0), o_bubble_cnt=1; the add appears on the following edge with o_aluOp=11.
- x0 and no-use cases: ld x0 followed by an instruction with rs1=0 → no stall. ld x5 followed by lui with rs1 field=5 and uses_rs1=0 → no stall.
- Flush plus hazard in the same cycle: i_flush=1 while haz=1 → o_stall=0, a bubble loads, o_flush_cnt=1, o_bubble_cnt unchanged.
- Hold: i_hold=1 for 3 cycles with i_flush=1 → outputs frozen, o_stall=1, counters unchanged. i_rst_n pulsed low mid-hold → all outputs 0 asynchronously, without waiting for a clock edge.
- Saturation: with CNT_W=2, force 5 consecutive flushes → o_flush_cnt sticks at 3.
